rom_load_sequencer: RTL and testbench

- Sequences the HPS ROM download into the core's program ROM and vector ROM.
- Arbitrates the ROM write/address ports between the downloader and the running CPU/vector generator.
- Generates the stretched, qualified core reset.
- Sits between the hps_io ioctl bus and the game top level; the game core only runs once a complete image has been loaded.

---
 rtl/rom_load_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_sequencer.sv
// Loads the HPS ROM image into the program/vector ROMs, arbitrates the ROM
// ports between loader and running core, and generates the stretched core reset.
module rom_load_sequencer #(
  parameter int PROG_AW     = 13,
  parameter int VEC_AW      = 11,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic               clk_25,
  input  logic               RESET_L,
  input  logic               ext_reset,
  input  logic               dn_download,
  input  logic               dn_wr,
  input  logic [15:0]        dn_addr,
  input  logic [7:0]         dn_data,
  input  logic [PROG_AW-1:0] cpu_prog_addr,
  input  logic [VEC_AW-1:0]  cpu_vec_addr,
  output logic [PROG_AW-1:0] prog_addr,
  output logic               prog_we,
  output logic [VEC_AW-1:0]  vec_addr,
  output logic               vec_we,
  output logic [7:0]         rom_wdata,
  output logic               loader_owns,
  output logic               rom_valid,
  output logic [7:0]         oor_cnt,
  output logic               core_reset_l
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam int              HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  // Region bounds kept one bit wider than dn_addr so the compares cannot wrap.
  localparam logic [16:0]       PROG_SIZE = 17'(1) << PROG_AW;
  localparam logic [16:0]       VEC_END   = PROG_SIZE + (17'(1) << VEC_AW);
  localparam logic [PROG_AW:0]  PROG_FULL = {1'b1, {PROG_AW{1'b0}}};
  localparam logic [VEC_AW:0]   VEC_FULL  = {1'b1, {VEC_AW{1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
  logic               dn_wr_prev_q;
  logic [PROG_AW:0]   prog_cnt_q, prog_cnt_d;
  logic [VEC_AW:0]    vec_cnt_q, vec_cnt_d;
  logic               rom_valid_q, rom_valid_d;
  logic [7:0]         oor_cnt_q, oor_cnt_d;
  logic               prog_we_q, prog_we_d;
  logic               vec_we_q, vec_we_d;
  logic [7:0]         rom_wdata_q, rom_wdata_d;
  logic [PROG_AW-1:0] ld_prog_addr_q, ld_prog_addr_d;
  logic [VEC_AW-1:0]  ld_vec_addr_q, ld_vec_addr_d;
  logic               loader_owns_q, loader_owns_d;
  logic               core_reset_l_q, core_reset_l_d;

  logic wr_accept;
  logic in_prog;
  logic in_vec;
  logic counts_full;
  logic enter_load;

  // A write is taken on the strobe's rising edge; the LOAD term keeps the
  // byte that arrives together with the falling dn_download.
  assign wr_accept   = dn_wr && !dn_wr_prev_q && (dn_download || (state_q == ST_LOAD));
  assign in_prog     = {1'b0, dn_addr} < PROG_SIZE;
  assign in_vec      = !in_prog && ({1'b0, dn_addr} < VEC_END);
  assign counts_full = (prog_cnt_q == PROG_FULL) && (vec_cnt_q == VEC_FULL);
  assign enter_load  = (state_d == ST_LOAD) && (state_q != ST_LOAD);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_BOOT: begin
        if (dn_download) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!dn_download) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (dn_download) begin
          state_d = ST_LOAD;
        end else if (ext_reset) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          // counts_full covers a last byte landing too late for rom_valid_q
          // when the hold is very short.
          state_d = (rom_valid_q || counts_full) ? ST_RUN : ST_BOOT;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      ST_RUN: begin
        if (dn_download) begin
          state_d = ST_LOAD;
        end else if (ext_reset) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    prog_we_d      = wr_accept && in_prog;
    vec_we_d       = wr_accept && in_vec;
    rom_wdata_d    = wr_accept ? dn_data : rom_wdata_q;
    ld_prog_addr_d = prog_we_d ? dn_addr[PROG_AW-1:0] : ld_prog_addr_q;
    ld_vec_addr_d  = vec_we_d ? VEC_AW'({1'b0, dn_addr} - PROG_SIZE) : ld_vec_addr_q;

    // A byte accepted on the LOAD entry edge counts into the fresh session.
    prog_cnt_d = enter_load ? '0 : prog_cnt_q;
    vec_cnt_d  = enter_load ? '0 : vec_cnt_q;
    if (prog_we_d && (prog_cnt_d != PROG_FULL)) prog_cnt_d = prog_cnt_d + 1'b1;
    if (vec_we_d && (vec_cnt_d != VEC_FULL))    vec_cnt_d  = vec_cnt_d + 1'b1;

    oor_cnt_d = oor_cnt_q;
    if (wr_accept && !in_prog && !in_vec && (oor_cnt_q != 8'hFF)) begin
      oor_cnt_d = oor_cnt_q + 8'd1;
    end

    rom_valid_d    = enter_load ? 1'b0 : (rom_valid_q || counts_full);
    loader_owns_d  = (state_d != ST_RUN);
    core_reset_l_d = (state_d == ST_RUN);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q        <= ST_BOOT;
      hold_cnt_q     <= '0;
      dn_wr_prev_q   <= 1'b0;
      prog_cnt_q     <= '0;
      vec_cnt_q      <= '0;
      rom_valid_q    <= 1'b0;
      oor_cnt_q      <= '0;
      prog_we_q      <= 1'b0;
      vec_we_q       <= 1'b0;
      rom_wdata_q    <= '0;
      ld_prog_addr_q <= '0;
      ld_vec_addr_q  <= '0;
      loader_owns_q  <= 1'b1;
      core_reset_l_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      dn_wr_prev_q   <= dn_wr;
      prog_cnt_q     <= prog_cnt_d;
      vec_cnt_q      <= vec_cnt_d;
      rom_valid_q    <= rom_valid_d;
      oor_cnt_q      <= oor_cnt_d;
      prog_we_q      <= prog_we_d;
      vec_we_q       <= vec_we_d;
      rom_wdata_q    <= rom_wdata_d;
      ld_prog_addr_q <= ld_prog_addr_d;
      ld_vec_addr_q  <= ld_vec_addr_d;
      loader_owns_q  <= loader_owns_d;
      core_reset_l_q <= core_reset_l_d;
    end
  end

  // The running core sees its own addresses with no added latency.
  assign prog_addr    = loader_owns_q ? ld_prog_addr_q : cpu_prog_addr;
  assign vec_addr     = loader_owns_q ? ld_vec_addr_q : cpu_vec_addr;
  assign prog_we      = prog_we_q && loader_owns_q;
  assign vec_we       = vec_we_q && loader_owns_q;
  assign rom_wdata    = rom_wdata_q;
  assign loader_owns  = loader_owns_q;
  assign rom_valid    = rom_valid_q;
  assign oor_cnt      = oor_cnt_q;
  assign core_reset_l = core_reset_l_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed-sequence bench for rom_load_sequencer with random data/addresses,
// checked against an image/count model of the download.
module tb_rom_load_sequencer;

  localparam int PROG_AW   = 13;
  localparam int VEC_AW    = 11;
  localparam int H         = 1024;
  localparam int PROG_SIZE = 1 << PROG_AW;
  localparam int VEC_SIZE  = 1 << VEC_AW;

  logic               clk_25 = 1'b0;
  logic               RESET_L = 1'b0;
  logic               ext_reset = 1'b0;
  logic               dn_download = 1'b0;
  logic               dn_wr = 1'b0;
  logic [15:0]        dn_addr = '0;
  logic [7:0]         dn_data = '0;
  logic [PROG_AW-1:0] cpu_prog_addr = '0;
  logic [VEC_AW-1:0]  cpu_vec_addr = '0;
  logic [PROG_AW-1:0] prog_addr;
  logic               prog_we;
  logic [VEC_AW-1:0]  vec_addr;
  logic               vec_we;
  logic [7:0]         rom_wdata;
  logic               loader_owns;
  logic               rom_valid;
  logic [7:0]         oor_cnt;
  logic               core_reset_l;

  rom_load_sequencer #(.PROG_AW(PROG_AW), .VEC_AW(VEC_AW), .HOLD_CYCLES(H)) dut (
    .clk_25(clk_25), .RESET_L(RESET_L), .ext_reset(ext_reset),
    .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .cpu_prog_addr(cpu_prog_addr), .cpu_vec_addr(cpu_vec_addr),
    .prog_addr(prog_addr), .prog_we(prog_we), .vec_addr(vec_addr), .vec_we(vec_we),
    .rom_wdata(rom_wdata), .loader_owns(loader_owns), .rom_valid(rom_valid),
    .oor_cnt(oor_cnt), .core_reset_l(core_reset_l)
  );

  always #20 clk_25 = ~clk_25;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: expected ROM images and per-session byte tallies.
  logic [7:0] exp_prog [PROG_SIZE];
  logic [7:0] exp_vec  [VEC_SIZE];
  int exp_oor  = 0;
  int sess_prog = 0;
  int sess_vec  = 0;

  // Observed ROM contents and write-enable pulse tallies.
  logic [7:0]         shadow_prog [PROG_SIZE];
  logic [7:0]         shadow_vec  [VEC_SIZE];
  int                 prog_pulses = 0;
  int                 vec_pulses  = 0;
  logic [PROG_AW-1:0] last_prog_addr = '0;
  logic [7:0]         last_prog_data = '0;

  always @(negedge clk_25) begin
    if (prog_we === 1'b1) begin
      prog_pulses               <= prog_pulses + 1;
      shadow_prog[prog_addr]    <= rom_wdata;
      last_prog_addr            <= prog_addr;
      last_prog_data            <= rom_wdata;
    end
    if (vec_we === 1'b1) begin
      vec_pulses                <= vec_pulses + 1;
      shadow_vec[vec_addr]      <= rom_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    int ia;
    ia = int'(a);
    if (ia < PROG_SIZE) begin
      exp_prog[ia] = d;
      sess_prog++;
    end else if (ia < PROG_SIZE + VEC_SIZE) begin
      exp_vec[ia - PROG_SIZE] = d;
      sess_vec++;
    end else if (exp_oor < 255) begin
      exp_oor++;
    end
  endtask

  function automatic logic model_valid();
    return (sess_prog >= PROG_SIZE) && (sess_vec >= VEC_SIZE);
  endfunction

  function automatic int rand_hi();
    return ($urandom_range(0, 7) == 0) ? 2 : 1;
  endfunction

  // One strobe: dn_wr high for hi_len cycles then low for one; 'last' drops
  // dn_download on the same edge the strobe rises.
  task automatic send_byte(input logic [15:0] a, input logic [7:0] d,
                           input bit accepted, input bit last, input int hi_len);
    @(negedge clk_25);
    dn_addr = a;
    dn_data = d;
    dn_wr   = 1'b1;
    if (last) dn_download = 1'b0;
    repeat (hi_len - 1) @(negedge clk_25);
    @(negedge clk_25);
    dn_wr = 1'b0;
    if (accepted) model_write(a, d);
  endtask

  function automatic int prog_mismatches();
    int m = 0;
    for (int i = 0; i < PROG_SIZE; i++) if (shadow_prog[i] !== exp_prog[i]) m++;
    return m;
  endfunction

  function automatic int vec_mismatches();
    int m = 0;
    for (int i = 0; i < VEC_SIZE; i++) if (shadow_vec[i] !== exp_vec[i]) m++;
    return m;
  endfunction

  initial begin
    int  k;
    int  p0, v0;
    bit  last;
    logic seen_run;
    logic [PROG_AW-1:0] pa;
    logic [VEC_AW-1:0]  va;

    // Reset state
    cpu_prog_addr = 13'h0ABC;
    cpu_vec_addr  = 11'h155;
    repeat (3) @(negedge clk_25);
    check("rst_prog_we", prog_we, 0);
    check("rst_vec_we", vec_we, 0);
    check("rst_wdata", rom_wdata, 0);
    check("rst_valid", rom_valid, 0);
    check("rst_oor", oor_cnt, 0);
    check("rst_core_reset", core_reset_l, 0);
    check("rst_owns", loader_owns, 1);
    check("rst_prog_addr", prog_addr, 0);
    RESET_L = 1'b1;
    repeat (2) @(negedge clk_25);

    // Full load, last byte coincides with dn_download falling
    dn_download = 1'b1;
    sess_prog = 0;
    sess_vec  = 0;
    p0 = prog_pulses;
    v0 = vec_pulses;
    for (int a = 0; a < PROG_SIZE + VEC_SIZE; a++) begin
      last = (a == PROG_SIZE + VEC_SIZE - 1);
      send_byte(16'(a), 8'($urandom_range(0, 255)), 1'b1, last, last ? 1 : rand_hi());
    end
    check("hold_core_reset", core_reset_l, 0);
    check("hold_owns", loader_owns, 1);
    k = 1;
    while (core_reset_l !== 1'b1 && k < 3 * H) begin
      @(negedge clk_25);
      k++;
    end
    check("load_to_run_delay", k, H + 1);
    check("full_prog_pulses", prog_pulses - p0, PROG_SIZE);
    check("full_vec_pulses", vec_pulses - v0, VEC_SIZE);
    check("full_prog_image", prog_mismatches(), 0);
    check("full_vec_image", vec_mismatches(), 0);
    check("vec_byte_0x2000", {24'b0, shadow_vec[0]}, {24'b0, exp_vec[0]});
    check("full_valid", rom_valid, model_valid());
    check("full_oor", oor_cnt, exp_oor);

    // RUN: CPU address pass-through, no write enables
    @(negedge clk_25);
    cpu_prog_addr = 13'h1234;
    #1;
    check("run_prog_addr_1234", prog_addr, 32'h1234);
    check("run_owns", loader_owns, 0);
    check("run_prog_we", prog_we, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_25);
      pa = PROG_AW'($urandom);
      va = VEC_AW'($urandom);
      cpu_prog_addr = pa;
      cpu_vec_addr  = va;
      #1;
      check("run_prog_pass", prog_addr, pa);
      check("run_vec_pass", vec_addr, va);
    end

    // ext_reset in RUN
    @(negedge clk_25);
    ext_reset = 1'b1;
    @(negedge clk_25);
    ext_reset = 1'b0;
    check("ext_core_reset_low", core_reset_l, 0);
    check("ext_owns", loader_owns, 1);
    check("ext_valid_kept", rom_valid, 1);
    k = 0;
    while (core_reset_l !== 1'b1 && k < 3 * H) begin
      @(negedge clk_25);
      k++;
    end
    check("ext_hold_len", k, H);
    check("ext_valid_after", rom_valid, model_valid());

    // ext_reset inside HOLD restarts the count
    @(negedge clk_25);
    ext_reset = 1'b1;
    @(negedge clk_25);
    ext_reset = 1'b0;
    repeat (50) @(negedge clk_25);
    ext_reset = 1'b1;
    @(negedge clk_25);
    ext_reset = 1'b0;
    k = 0;
    while (core_reset_l !== 1'b1 && k < 3 * H) begin
      @(negedge clk_25);
      k++;
    end
    check("hold_reload_len", k, H);

    // Download restart during HOLD
    @(negedge clk_25);
    ext_reset = 1'b1;
    @(negedge clk_25);
    ext_reset = 1'b0;
    repeat (20) @(negedge clk_25);
    check("restart_valid_before", rom_valid, 1);
    dn_download = 1'b1;
    sess_prog = 0;
    sess_vec  = 0;
    @(negedge clk_25);
    check("restart_valid_cleared", rom_valid, model_valid());
    check("restart_core_reset", core_reset_l, 0);
    check("restart_owns", loader_owns, 1);

    // Out-of-range bytes
    p0 = prog_pulses;
    v0 = vec_pulses;
    send_byte(16'h2800, 8'h11, 1'b1, 1'b0, 1);
    send_byte(16'hFFFF, 8'h22, 1'b1, 1'b0, 1);
    repeat (2) @(negedge clk_25);
    check("oor_no_prog_we", prog_pulses - p0, 0);
    check("oor_no_vec_we", vec_pulses - v0, 0);
    check("oor_two", oor_cnt, exp_oor);

    // Long strobe gives a single write
    p0 = prog_pulses;
    send_byte(16'h0010, 8'hA5, 1'b1, 1'b0, 5);
    @(negedge clk_25);
    check("long_strobe_pulses", prog_pulses - p0, 1);
    check("long_strobe_addr", last_prog_addr, 32'h010);
    check("long_strobe_data", last_prog_data, 32'hA5);

    for (int i = 0; i < 298; i++) begin
      send_byte(16'($urandom_range(32'h2800, 32'hFFFF)), 8'($urandom), 1'b1, 1'b0, 1);
    end
    repeat (2) @(negedge clk_25);
    check("oor_saturate", oor_cnt, exp_oor);

    // Short load: program region only
    p0 = prog_pulses;
    for (int a = 0; a < PROG_SIZE; a++) begin
      last = (a == PROG_SIZE - 1);
      send_byte(16'(a), 8'($urandom_range(0, 255)), 1'b1, last, last ? 1 : rand_hi());
    end
    seen_run = 1'b0;
    for (int i = 0; i < 2 * H + 20; i++) begin
      @(negedge clk_25);
      seen_run = seen_run | (core_reset_l !== 1'b0);
    end
    check("short_core_reset_held", seen_run, 0);
    check("short_valid", rom_valid, model_valid());
    check("short_prog_pulses", prog_pulses - p0, PROG_SIZE);
    check("short_prog_image", prog_mismatches(), 0);
    check("short_owns", loader_owns, 1);

    // Strobe without download outside LOAD is ignored
    p0 = prog_pulses;
    send_byte(16'h0020, 8'h5A, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk_25);
    check("idle_strobe_ignored", prog_pulses - p0, 0);
    check("idle_oor_kept", oor_cnt, exp_oor);

    // Asynchronous reset in the middle of a load
    @(negedge clk_25);
    dn_download = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(16'(i + 100), 8'($urandom), 1'b1, 1'b0, 1);
    @(negedge clk_25);
    dn_addr = 16'h0005;
    dn_data = 8'h77;
    dn_wr   = 1'b1;
    @(posedge clk_25);
    #1;
    check("pre_rst_prog_we", prog_we, 1);
    check("pre_rst_prog_addr", prog_addr, 32'h005);
    check("pre_rst_wdata", rom_wdata, 32'h77);
    RESET_L = 1'b0;
    exp_oor = 0;
    #1;
    check("async_prog_we", prog_we, 0);
    check("async_vec_we", vec_we, 0);
    check("async_core_reset", core_reset_l, 0);
    check("async_valid", rom_valid, 0);
    check("async_oor", oor_cnt, exp_oor);
    check("async_wdata", rom_wdata, 0);
    check("async_owns", loader_owns, 1);
    dn_wr = 1'b0;
    dn_download = 1'b0;
    repeat (3) @(negedge clk_25);
    RESET_L = 1'b1;
    repeat (3) @(negedge clk_25);
    check("post_rst_core_reset", core_reset_l, 0);
    check("post_rst_oor", oor_cnt, exp_oor);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
